// File: rtl/serial_frame_arbiter_if.sv
// Bundle between the serial sources, the shared deserializer
// and the frame consumer, as seen by serial_frame_arbiter.
interface serial_frame_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int FRAME_BITS = 256
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = $clog2(FRAME_BITS + 1);

  logic [NUM_SRC-1:0] REQ;
  logic [NUM_SRC-1:0] SERIAL_SRC;
  logic [NUM_SRC-1:0] GNT;
  logic               DES_READY;
  logic               DES_SERIAL;
  logic               DES_COMPLETE;
  logic               FRAME_VALID;
  logic [SW-1:0]      FRAME_SRC;
  logic               FRAME_ACK;
  logic               ABORT;
  logic               TIMEOUT_ERR;
  logic [BW-1:0]      BIT_COUNT;

  modport master (
    output REQ, SERIAL_SRC, DES_COMPLETE, FRAME_ACK,
    input  GNT, DES_READY, DES_SERIAL, FRAME_VALID,
    input  FRAME_SRC, ABORT, TIMEOUT_ERR, BIT_COUNT
  );

  modport slave (
    input  REQ, SERIAL_SRC, DES_COMPLETE, FRAME_ACK,
    output GNT, DES_READY, DES_SERIAL, FRAME_VALID,
    output FRAME_SRC, ABORT, TIMEOUT_ERR, BIT_COUNT
  );
endinterface

// File: rtl/serial_frame_arbiter.sv
// Round-robin owner of one shared deserializer: grants a serial
// source, streams its frame, then sequences complete/ack.
module serial_frame_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FRAME_BITS = 256,
  parameter int TIMEOUT    = 64
) (
  input logic                   CLK,
  input logic                   RESET,
  serial_frame_arbiter_if.slave bus
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t        st;
  state_t        nxt;
  logic [SW-1:0] ptr;
  logic [SW-1:0] src;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic          abort_q;
  logic          terr_q;
  logic          abort_c;
  logic          terr_c;
  logic          hit;
  logic          ptr_ld;
  logic          last_bit;
  logic          tmo;
  int            idx;

  // first requester strictly after the last owner, wrapping
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    idx  = 0;
    cand = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx  = (int'(ptr) + i) % NUM_SRC;
      cand = SW'(idx);
      if (!hit && bus.REQ[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  assign last_bit = bcnt == BW'(FRAME_BITS - 1);
  assign tmo      = tcnt == TW'(TIMEOUT - 1);

  always_comb begin
    nxt     = st;
    abort_c = 1'b0;
    terr_c  = 1'b0;
    ptr_ld  = 1'b0;
    unique case (st)
      IDLE: begin
        if (hit) nxt = STREAM;
      end
      STREAM: begin
        if (!bus.REQ[src]) begin
          nxt     = IDLE;
          abort_c = 1'b1;
        end else if (last_bit) begin
          nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.DES_COMPLETE) begin
          nxt = HOLD;
        end else if (tmo) begin
          nxt    = IDLE;
          terr_c = 1'b1;
          ptr_ld = 1'b1;
        end
      end
      HOLD: begin
        if (bus.FRAME_ACK) begin
          nxt    = IDLE;
          ptr_ld = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st      <= IDLE;
      ptr     <= SW'(NUM_SRC - 1);
      src     <= '0;
      bcnt    <= '0;
      tcnt    <= '0;
      abort_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      st      <= nxt;
      abort_q <= abort_c;
      terr_q  <= terr_c;
      if (st == IDLE && hit) src <= win;
      if (ptr_ld) ptr <= src;
      if (st == IDLE || nxt == IDLE) bcnt <= '0;
      else if (st == STREAM) bcnt <= bcnt + 1'b1;
      tcnt <= (st == WAIT_DONE) ? tcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    bus.GNT = '0;
    if (st == STREAM) bus.GNT[src] = 1'b1;
  end

  assign bus.DES_READY   = (st == STREAM) || (st == WAIT_DONE);
  assign bus.DES_SERIAL  = (st == STREAM) && bus.SERIAL_SRC[src];
  assign bus.FRAME_VALID = st == HOLD;
  assign bus.FRAME_SRC   = src;
  assign bus.ABORT       = abort_q;
  assign bus.TIMEOUT_ERR = terr_q;
  assign bus.BIT_COUNT   = bcnt;
endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: frame-level model checked
// every cycle plus directed scenarios with literal expectations.
module tb_serial_frame_arbiter;
  localparam int NS = 4;
  localparam int FB = 256;
  localparam int TO = 64;

  logic          CLK;
  logic          RESET;
  logic [NS-1:0] bg;
  logic          use_pat;
  logic          pat_bit;
  logic [255:0]  pat;
  logic [255:0]  cap;
  int            total = 0;
  int            bad = 0;

  serial_frame_arbiter_if #(.NUM_SRC(NS), .FRAME_BITS(FB)) bus ();

  serial_frame_arbiter #(
    .NUM_SRC(NS), .FRAME_BITS(FB), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  assign bus.SERIAL_SRC =
    use_pat ? {bg[3], pat_bit, bg[1:0]} : bg;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    bg = '0;
    forever begin
      @(posedge CLK);
      #1 bg = 4'($urandom);
    end
  end

  task automatic chk(string nm, logic [255:0] act,
                     logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // frame-level model: phase 0 idle, 1 streaming,
  // 2 waiting for complete, 3 holding for ack
  int m_mode, m_ptr, m_src, m_bits, m_wait;
  bit m_abort, m_terr;

  task automatic model_reset();
    m_mode = 0; m_ptr = NS - 1; m_src = 0;
    m_bits = 0; m_wait = 0; m_abort = 0; m_terr = 0;
  endtask

  task automatic model_step(logic [NS-1:0] req,
                            logic cmp, logic ack);
    int w;
    w = -1;
    m_abort = 0;
    m_terr  = 0;
    case (m_mode)
      0: begin
        for (int k = 1; k <= NS; k++)
          if (w < 0 && req[(m_ptr + k) % NS]) w = (m_ptr + k) % NS;
        if (w >= 0) begin
          m_src = w; m_bits = 0; m_mode = 1;
        end
      end
      1: begin
        if (!req[m_src]) begin
          m_mode = 0; m_abort = 1; m_bits = 0;
        end else begin
          m_bits++;
          if (m_bits == FB) begin
            m_mode = 2; m_wait = 0;
          end
        end
      end
      2: begin
        if (cmp) m_mode = 3;
        else if (m_wait == TO - 1) begin
          m_mode = 0; m_terr = 1; m_ptr = m_src; m_bits = 0;
        end else m_wait++;
      end
      default: begin
        if (ack) begin
          m_mode = 0; m_ptr = m_src; m_bits = 0;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RESET);
      if (!RESET) model_reset();
      else model_step(bus.REQ, bus.DES_COMPLETE, bus.FRAME_ACK);
    end
  end

  int run, wd, last_wd, fv_total, ab_total, te_total;
  int order[$];
  int runs[$];

  initial begin
    logic [NS-1:0] e_gnt;
    int g;
    run = 0; wd = 0; last_wd = 0;
    fv_total = 0; ab_total = 0; te_total = 0;
    cap = '0;
    forever begin
      @(negedge CLK);
      e_gnt = '0;
      if (m_mode == 1) e_gnt[m_src] = 1'b1;
      chk("gnt", bus.GNT, e_gnt);
      chk("des_ready", bus.DES_READY, m_mode == 1 || m_mode == 2);
      chk("des_serial", bus.DES_SERIAL,
          m_mode == 1 && bus.SERIAL_SRC[m_src]);
      chk("frame_valid", bus.FRAME_VALID, m_mode == 3);
      chk("frame_src", bus.FRAME_SRC, m_src);
      chk("abort", bus.ABORT, m_abort);
      chk("timeout_err", bus.TIMEOUT_ERR, m_terr);
      chk("bit_count", bus.BIT_COUNT, m_bits);
      if (bus.GNT != '0) begin
        g = 0;
        for (int k = 0; k < NS; k++) if (bus.GNT[k]) g = k;
        if (run == 0) order.push_back(g);
        run++;
        cap = {cap[254:0], bus.DES_SERIAL};
      end else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (bus.TIMEOUT_ERR) last_wd = wd;
      wd = (bus.DES_READY && bus.GNT == '0) ? wd + 1 : 0;
      fv_total += int'(bus.FRAME_VALID);
      ab_total += int'(bus.ABORT);
      te_total += int'(bus.TIMEOUT_ERR);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  function automatic bit cond(int sel, int val);
    case (sel)
      0: return bus.GNT == '0 && !bus.DES_READY && !bus.FRAME_VALID;
      1: return bus.DES_READY && bus.GNT == '0;
      2: return bus.FRAME_VALID;
      3: return bus.GNT != '0 && int'(bus.BIT_COUNT) == val;
      4: return bus.TIMEOUT_ERR;
      default: return bus.GNT != '0;
    endcase
  endfunction

  task automatic wait_on(string nm, int sel, int val, int budget);
    int n;
    n = 0;
    while (!cond(sel, val) && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (!cond(sel, val)) begin
      bad++;
      $display("FAIL wait_%s: got no event want within %0d", nm, budget);
    end
  endtask

  task automatic finish_frame(int cdly, int adly);
    tick(cdly);
    bus.DES_COMPLETE = 1'b1;
    wait_on("fv", 2, 0, 50);
    bus.DES_COMPLETE = 1'b0;
    tick(adly);
    bus.FRAME_ACK = 1'b1;
    tick(1);
    bus.FRAME_ACK = 1'b0;
  endtask

  initial begin
    int rr_exp[5];
    int fv0, te0;
    logic [255:0] sh;
    rr_exp = '{0, 1, 2, 3, 0};
    RESET = 1'b1;
    use_pat = 1'b0;
    pat_bit = 1'b0;
    bus.REQ = '0;
    bus.DES_COMPLETE = 1'b0;
    bus.FRAME_ACK = 1'b0;
    #3 RESET = 1'b0;
    #1;
    chk("rst_gnt", bus.GNT, 4'b0000);
    chk("rst_ready", bus.DES_READY, 1'b0);
    chk("rst_bitcnt", bus.BIT_COUNT, 0);
    chk("rst_fv", bus.FRAME_VALID, 1'b0);
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b1;
    tick(1);

    // round robin with every source requesting
    order.delete();
    runs.delete();
    bus.REQ = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_on("gnt", 5, 0, 20);
      if (f == 4) bus.REQ = 4'b0001;
      wait_on("wait", 1, 0, 300);
      if (f == 4) bus.REQ = 4'b0000;
      finish_frame(3, 2);
    end
    tick(2);
    chk("rr_count", order.size(), 5);
    for (int f = 0; f < 5; f++) begin
      if (f < order.size()) chk("rr_order", order[f], rr_exp[f]);
      if (f < runs.size()) chk("rr_len", runs[f], FB);
    end

    // abort at bit 100, pointer must stay on source 0
    wait_on("idle", 0, 0, 20);
    bus.REQ = 4'b0010;
    wait_on("bc100", 3, 100, 400);
    bus.REQ = 4'b0000;
    tick(1);
    chk("abort_pulse", bus.ABORT, 1'b1);
    chk("abort_ready", bus.DES_READY, 1'b0);
    bus.REQ = 4'b1010;
    wait_on("gnt", 5, 0, 20);
    chk("abort_regrant", bus.FRAME_SRC, 1);
    chk("abort_len", runs[$], 101);
    wait_on("wait", 1, 0, 300);
    bus.REQ = 4'b0000;
    finish_frame(1, 0);
    chk("abort_count", ab_total, 1);

    // single requester 2 with an A5 pattern
    wait_on("idle", 0, 0, 20);
    pat = {32{8'hA5}};
    sh = pat;
    cap = '0;
    use_pat = 1'b1;
    bus.REQ = 4'b0100;
    tick(1);
    for (int k = 0; k < FB; k++) begin
      pat_bit = sh[255];
      sh = sh << 1;
      tick(1);
    end
    bus.REQ = 4'b0000;
    use_pat = 1'b0;
    tick(9);
    bus.DES_COMPLETE = 1'b1;
    tick(1);
    chk("single_fv", bus.FRAME_VALID, 1'b1);
    chk("single_src", bus.FRAME_SRC, 2);
    bus.DES_COMPLETE = 1'b0;
    bus.FRAME_ACK = 1'b1;
    tick(1);
    bus.FRAME_ACK = 1'b0;
    chk("single_idle", bus.FRAME_VALID, 1'b0);
    chk("single_len", runs[$], FB);
    chk("single_who", order[$], 2);
    chk("single_data", cap, pat);

    // timeout with source 3
    wait_on("idle", 0, 0, 20);
    fv0 = fv_total;
    te0 = te_total;
    bus.REQ = 4'b1000;
    wait_on("wait", 1, 0, 300);
    bus.REQ = 4'b0000;
    wait_on("terr", 4, 0, 200);
    tick(1);
    chk("to_latency", last_wd, TO);
    chk("to_pulses", te_total - te0, 1);
    chk("to_no_fv", fv_total - fv0, 0);
    chk("to_who", order[$], 3);

    // ack held high: hold lasts one cycle
    wait_on("idle", 0, 0, 20);
    fv0 = fv_total;
    bus.FRAME_ACK = 1'b1;
    bus.REQ = 4'b0100;
    wait_on("wait", 1, 0, 300);
    bus.REQ = 4'b0000;
    bus.DES_COMPLETE = 1'b1;
    wait_on("fv", 2, 0, 50);
    bus.DES_COMPLETE = 1'b0;
    tick(3);
    bus.FRAME_ACK = 1'b0;
    chk("ack_hold", fv_total - fv0, 1);

    // reset mid-stream, then 1 must beat 3
    wait_on("idle", 0, 0, 20);
    bus.REQ = 4'b0100;
    wait_on("bc37", 3, 37, 400);
    RESET = 1'b0;
    #1;
    chk("mid_gnt", bus.GNT, 4'b0000);
    chk("mid_ready", bus.DES_READY, 1'b0);
    chk("mid_serial", bus.DES_SERIAL, 1'b0);
    chk("mid_bitcnt", bus.BIT_COUNT, 0);
    chk("mid_src", bus.FRAME_SRC, 0);
    bus.REQ = 4'b1010;
    tick(2);
    RESET = 1'b1;
    tick(1);
    chk("post_src", bus.FRAME_SRC, 1);
    chk("post_gnt", bus.GNT, 4'b0010);
    bus.REQ = 4'b0000;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
